rps_match_ctrl: RTL and testbench

Parametrised successor to the single-round guess-hand controller. It consumes decoded UART bytes (uart_rx rx_data/rx_data_valid) and plays rock-paper-scissors against an LFSR opponent. It keeps per-side scores over a best-of match and holds a timed reveal window. It feeds the display block with show, both hands, the round result, scores and the match-over status.

---
 rtl/rps_pkg.sv | 46 ++++
 rtl/rps_lfsr.sv | 30 +++
 rtl/rps_match_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rps_match_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Rock-paper-scissors match controller: shared types, command bytes and the
// round judge. Imported by rps_lfsr and rps_match_ctrl.
package rps_pkg;

   typedef enum logic [1:0] {
      H_ROCK     = 2'd0,
      H_PAPER    = 2'd1,
      H_SCISSORS = 2'd2,
      H_NONE     = 2'd3
   } hand_t;

   typedef enum logic [1:0] {
      R_NONE = 2'd0,
      R_WIN  = 2'd1,
      R_LOSE = 2'd2,
      R_DRAW = 2'd3
   } result_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_R_UC = 8'h52;
   localparam logic [7:0] ASCII_R_LC = 8'h72;
   localparam logic [7:0] ASCII_P_UC = 8'h50;
   localparam logic [7:0] ASCII_P_LC = 8'h70;
   localparam logic [7:0] ASCII_S_UC = 8'h53;
   localparam logic [7:0] ASCII_S_LC = 8'h73;
   localparam logic [7:0] ASCII_N_UC = 8'h4E;
   localparam logic [7:0] ASCII_N_LC = 8'h6E;

   // Player-relative outcome: d = (p - c) mod 3, 1 = player wins, 2 = cpu wins.
   function automatic result_t judge(input hand_t p, input hand_t c);
      logic [2:0] d;
      d = {1'b0, p} + 3'd3 - {1'b0, c};
      if (d >= 3'd3) d = d - 3'd3;
      case (d)
         3'd1:    judge = R_WIN;
         3'd2:    judge = R_LOSE;
         default: judge = R_DRAW;
      endcase
   endfunction

endpackage

// File: rtl/rps_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a 0..2 pick.
// Ports: clk, rst_n (async, active-low), pick_o (rock/paper/scissors).
module rps_lfsr
   import rps_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic  clk,
   input  logic  rst_n,
   output hand_t pick_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   // Reject the value 3 by falling back to the next bit pair, then to rock.
   always_comb begin
      if (lfsr_q[1:0] != 2'b11)      pick_o = hand_t'(lfsr_q[1:0]);
      else if (lfsr_q[3:2] != 2'b11) pick_o = hand_t'(lfsr_q[3:2]);
      else                           pick_o = H_ROCK;
   end

endmodule

// File: rtl/rps_match_ctrl.sv
// Best-of match controller: decodes UART command bytes, plays against an LFSR
// (or fixed) opponent, keeps scores and holds a timed reveal window.
// Ports: clk, rst_n; rx_data/rx_data_valid command input; show, player_hand,
// cpu_hand, result, player_score, cpu_score, match_over, winner to display.
//
// state  | meaning
// IDLE   | waiting for a hand byte; last round's hands/result still held
// SHOW   | reveal window running, timer counting down to zero
// OVER   | a side reached WIN_TARGET; everything frozen until 'N'
module rps_match_ctrl
   import rps_pkg::*;
#(
   parameter int          CLK_FRE     = 50,
   parameter int          SHOW_MS     = 2000,
   parameter int          SHOW_CYCLES = CLK_FRE * 1000 * SHOW_MS,
   parameter int          SCORE_W     = 4,
   parameter int          WIN_TARGET  = 3,
   parameter int          FIXED_CPU   = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         rx_data,
   input  logic               rx_data_valid,
   output logic               show,
   output logic [1:0]         player_hand,
   output logic [1:0]         cpu_hand,
   output logic [1:0]         result,
   output logic [SCORE_W-1:0] player_score,
   output logic [SCORE_W-1:0] cpu_score,
   output logic               match_over,
   output logic               winner
);

   localparam int                 TMR_W    = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(SHOW_CYCLES - 1);
   localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(WIN_TARGET);

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   hand_t               p_hand_q, p_hand_d;
   hand_t               c_hand_q, c_hand_d;
   result_t             res_q, res_d;
   logic [SCORE_W-1:0]  p_score_q, p_score_d;
   logic [SCORE_W-1:0]  c_score_q, c_score_d;
   logic                winner_q, winner_d;

   hand_t   lfsr_pick;
   hand_t   cpu_pick;
   hand_t   cmd_hand;
   logic    cmd_is_hand;
   logic    cmd_new;
   result_t round_res;
   logic    target_hit;

   rps_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .pick_o (lfsr_pick)
   );

   assign cpu_pick = (FIXED_CPU < 3) ? hand_t'(FIXED_CPU[1:0]) : lfsr_pick;

   always_comb begin
      cmd_is_hand = 1'b0;
      cmd_hand    = H_NONE;
      cmd_new     = 1'b0;
      if (rx_data_valid) begin
         case (rx_data)
            ASCII_R_UC, ASCII_R_LC: begin cmd_is_hand = 1'b1; cmd_hand = H_ROCK;     end
            ASCII_P_UC, ASCII_P_LC: begin cmd_is_hand = 1'b1; cmd_hand = H_PAPER;    end
            ASCII_S_UC, ASCII_S_LC: begin cmd_is_hand = 1'b1; cmd_hand = H_SCISSORS; end
            ASCII_N_UC, ASCII_N_LC: cmd_new = 1'b1;
            default: ;
         endcase
      end
   end

   assign round_res  = judge(cmd_hand, cpu_pick);
   assign target_hit = (p_score_q == TARGET) || (c_score_q == TARGET);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         p_hand_q  <= H_NONE;
         c_hand_q  <= H_NONE;
         res_q     <= R_NONE;
         p_score_q <= '0;
         c_score_q <= '0;
         winner_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         p_hand_q  <= p_hand_d;
         c_hand_q  <= c_hand_d;
         res_q     <= res_d;
         p_score_q <= p_score_d;
         c_score_q <= c_score_d;
         winner_q  <= winner_d;
      end
   end

   // 'N' wins over everything, including timer expiry on the same cycle.
   always_comb begin
      state_d = state_q;
      if (cmd_new) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (cmd_is_hand) state_d = S_SHOW;
            S_SHOW:  if (timer_q == '0) state_d = target_hit ? S_OVER : S_IDLE;
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      timer_d   = timer_q;
      p_hand_d  = p_hand_q;
      c_hand_d  = c_hand_q;
      res_d     = res_q;
      p_score_d = p_score_q;
      c_score_d = c_score_q;
      winner_d  = winner_q;
      if (cmd_new) begin
         timer_d   = '0;
         p_hand_d  = H_NONE;
         c_hand_d  = H_NONE;
         res_d     = R_NONE;
         p_score_d = '0;
         c_score_d = '0;
         winner_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_is_hand) begin
                  p_hand_d = cmd_hand;
                  c_hand_d = cpu_pick;
                  res_d    = round_res;
                  timer_d  = TMR_LOAD;
                  if (round_res == R_WIN)  p_score_d = p_score_q + SCORE_W'(1);
                  if (round_res == R_LOSE) c_score_d = c_score_q + SCORE_W'(1);
               end
            end
            S_SHOW: begin
               if (timer_q != '0)   timer_d  = timer_q - TMR_W'(1);
               else if (target_hit) winner_d = (c_score_q == TARGET);
            end
            default: ;
         endcase
      end
   end

   assign show         = (state_q != S_IDLE);
   assign match_over   = (state_q == S_OVER);
   assign winner       = winner_q;
   assign player_hand  = p_hand_q;
   assign cpu_hand     = c_hand_q;
   assign result       = res_q;
   assign player_score = p_score_q;
   assign cpu_score    = c_score_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
module tb_rps_match_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;

   logic       show_w [4];
   logic [1:0] ph_w   [4];
   logic [1:0] ch_w   [4];
   logic [1:0] res_w  [4];
   logic [3:0] ps_w   [4];
   logic [3:0] cs_w   [4];
   logic       mo_w   [4];
   logic       win_w  [4];

   int n_cmp = 0;
   int n_bad = 0;

   // Instance k has FIXED_CPU = k: 0 rock, 1 paper, 2 scissors, 3 LFSR.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      rps_match_ctrl #(
         .SHOW_CYCLES (20),
         .SCORE_W     (4),
         .WIN_TARGET  (3),
         .FIXED_CPU   (g),
         .LFSR_SEED   (16'hACE1)
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .rx_data       (rx_data),
         .rx_data_valid (rx_valid),
         .show          (show_w[g]),
         .player_hand   (ph_w[g]),
         .cpu_hand      (ch_w[g]),
         .result        (res_w[g]),
         .player_score  (ps_w[g]),
         .cpu_score     (cs_w[g]),
         .match_over    (mo_w[g]),
         .winner        (win_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: same polynomial, written as a tap mask.
   logic [15:0] m_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
   end

   function automatic int m_pick(input logic [15:0] l);
      if (l[1:0] != 2'b11) return int'(l[1:0]);
      if (l[3:2] != 2'b11) return int'(l[3:2]);
      return 0;
   endfunction

   function automatic int m_judge(input int p, input int c);
      if (p == c) return 3;
      if ((p == 0 && c == 2) || (p == 1 && c == 0) || (p == 2 && c == 1)) return 1;
      return 2;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int k);
      chk({tag, "_show"},  int'(show_w[k]), 0);
      chk({tag, "_ph"},    int'(ph_w[k]),   3);
      chk({tag, "_ch"},    int'(ch_w[k]),   3);
      chk({tag, "_res"},   int'(res_w[k]),  0);
      chk({tag, "_ps"},    int'(ps_w[k]),   0);
      chk({tag, "_cs"},    int'(cs_w[k]),   0);
      chk({tag, "_mo"},    int'(mo_w[k]),   0);
      chk({tag, "_win"},   int'(win_w[k]),  0);
   endtask

   // Byte is valid for one cycle; returns at the negedge after the sampling edge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      int h;
      int exp_c;
      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle("rst0", 0);
      chk_idle("rst3", 3);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Paper vs rock / paper vs scissors
      send("p");
      chk("t1_show", int'(show_w[0]), 1);
      chk("t1_ph",   int'(ph_w[0]),   1);
      chk("t1_ch",   int'(ch_w[0]),   0);
      chk("t1_res",  int'(res_w[0]),  1);
      chk("t1_ps",   int'(ps_w[0]),   1);
      chk("t2_res",  int'(res_w[2]),  2);
      chk("t2_cs",   int'(cs_w[2]),   1);
      cnt = 0;
      while (show_w[0] && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("t1_win_len", cnt, 20);
      chk("t1_hold_ph", int'(ph_w[0]), 1);

      send("s");
      chk("t2_draw_res", int'(res_w[2]), 3);
      chk("t2_draw_cs",  int'(cs_w[2]),  1);
      chk("t2_draw_ps",  int'(ps_w[2]),  0);
      chk("t2_r0_cs",    int'(cs_w[0]),  1);
      repeat (22) @(negedge clk);

      // Three scissors vs paper -> player match win
      send("N");
      chk_idle("t3_new", 1);
      for (int i = 0; i < 3; i++) begin
         send("S");
         if (i < 2) repeat (22) @(negedge clk);
      end
      chk("t3_ps3",     int'(ps_w[1]), 3);
      chk("t3_mo_pre",  int'(mo_w[1]), 0);
      repeat (22) @(negedge clk);
      chk("t3_mo",      int'(mo_w[1]),   1);
      chk("t3_win",     int'(win_w[1]),  0);
      chk("t3_show",    int'(show_w[1]), 1);
      chk("t3_ps",      int'(ps_w[1]),   3);
      chk("t3_r0_mo",   int'(mo_w[0]),   1);
      chk("t3_r0_win",  int'(win_w[0]),  1);
      chk("t3_r0_cs",   int'(cs_w[0]),   3);
      chk("t3_r2_show", int'(show_w[2]), 0);
      chk("t3_r2_mo",   int'(mo_w[2]),   0);
      send("R");
      @(negedge clk);
      chk("t3_over_ph",  int'(ph_w[1]),  2);
      chk("t3_over_res", int'(res_w[1]), 1);
      chk("t3_over_ps",  int'(ps_w[1]),  3);
      chk("t3_over_mo",  int'(mo_w[1]),  1);
      send("n");
      chk_idle("t3_clr", 1);
      chk_idle("t3_clr0", 0);

      // Extra hand bytes mid-window and on the expiry cycle
      send("R");
      chk("t4_res", int'(res_w[1]), 2);
      chk("t4_cs",  int'(cs_w[1]),  1);
      repeat (4) @(negedge clk);
      rx_data = "S"; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("t4_mid_ph", int'(ph_w[1]), 0);
      chk("t4_mid_cs", int'(cs_w[1]), 1);
      chk("t4_mid_ps", int'(ps_w[1]), 0);
      repeat (14) @(negedge clk);
      chk("t4_last_show", int'(show_w[1]), 1);
      rx_data = "P"; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("t4_exp_show", int'(show_w[1]), 0);
      chk("t4_exp_ph",   int'(ph_w[1]),   0);
      chk("t4_exp_cs",   int'(cs_w[1]),   1);
      chk("t4_exp_ps",   int'(ps_w[1]),   0);
      @(negedge clk);
      chk("t4_after_show", int'(show_w[1]), 0);

      // 'N' and reset mid-window
      send("N");
      send("P");
      chk("t5_ps", int'(ps_w[0]), 1);
      repeat (5) @(negedge clk);
      send("N");
      chk_idle("t5_new", 0);
      send("R");
      chk("t5_cs", int'(cs_w[1]), 1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_show", int'(show_w[1]), 0);
      chk("t5_rst_ph",   int'(ph_w[1]),   3);
      chk("t5_rst_ch",   int'(ch_w[1]),   3);
      chk("t5_rst_cs",   int'(cs_w[1]),   0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // LFSR opponent against the reference model
      for (int r = 0; r < 64; r++) begin
         send("N");
         repeat (r % 5) @(negedge clk);
         h = (r + r / 3) % 3;
         @(negedge clk);
         rx_data  = (h == 0) ? "R" : (h == 1) ? "P" : "S";
         rx_valid = 1'b1;
         exp_c    = m_pick(m_lfsr);
         @(negedge clk);
         rx_valid = 1'b0;
         chk($sformatf("t6_ch_%0d", r),  int'(ch_w[3]),  exp_c);
         chk($sformatf("t6_res_%0d", r), int'(res_w[3]), m_judge(h, exp_c));
      end
      send("N");
      send("x");
      chk("t6_x_show", int'(show_w[3]), 0);
      chk("t6_x_ph",   int'(ph_w[3]),   3);
      send(8'h00);
      chk("t6_0_show", int'(show_w[3]), 0);
      chk("t6_0_res",  int'(res_w[3]),  0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
